mux_nto1_reg: RTL and testbench

//  Registered N-input, WIDTH-bit multiplexer with valid/ready handshake on every channel.

---
 rtl/mux_pkg.sv | 20 ++
 rtl/rr_pointer.sv | 42 ++++
 rtl/mux_nto1_reg.sv | 90 +++++++++
 tb/tb_mux_nto1_reg.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared constants and helpers for the registered N:1 multiplexer.
package mux_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_N     = 4;
    localparam int DEFAULT_CNT_W = 16;

    // Smallest b with 2**b >= value; clog2(1) == 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_pointer.sv
// Round-robin grant pointer: picks the first valid channel after the last
// accepted one and advances only when that channel's word is taken.
module rr_pointer
    import mux_pkg::*;
#(
    parameter int N     = DEFAULT_N,
    parameter int SEL_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     in_valid,
    input  logic             accept,
    output logic [SEL_W-1:0] grant_idx,
    output logic             grant_valid
);

    logic [SEL_W-1:0] ptr;

    always_comb begin
        int idx;
        idx         = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!grant_valid && in_valid[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = SEL_W'(idx);
            end
        end
    end

    // Reset to N-1 so that channel 0 is searched first.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= SEL_W'(N - 1);
        end else if (accept) begin
            ptr <= grant_idx;
        end
    end

endmodule

// File: rtl/mux_nto1_reg.sv
// Registered N:1 valid/ready multiplexer with an accepted-word counter.
// Define MUX_RR_ARB_EN for round-robin arbitration; otherwise sel picks the channel.
module mux_nto1_reg
    import mux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int N     = DEFAULT_N,
    parameter int SEL_W = 2,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [SEL_W-1:0]   sel,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_ch,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CNT_W-1:0]   out_count
);

    if (SEL_W < clog2(N)) begin : g_sel_w_check
        $error("mux_nto1_reg: SEL_W too narrow for N channels");
    end
    if (N < 2) begin : g_n_check
        $error("mux_nto1_reg: N must be at least 2");
    end

    logic             load_en;
    logic             accept;
    logic [SEL_W-1:0] grant_idx;
    logic             grant_valid;
    logic [WIDTH-1:0] grant_data;

`ifdef MUX_RR_ARB_EN
    logic unused_sel;
    assign unused_sel = ^sel;

    rr_pointer #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_rr_pointer (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .accept      (accept),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );
`else
    // Out-of-range selects grant nothing rather than aliasing onto a channel.
    assign grant_idx   = sel;
    assign grant_valid = (int'(sel) < N);
`endif

    assign load_en = !out_valid || out_ready;

    always_comb begin
        in_ready   = '0;
        grant_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_idx == SEL_W'(i)) begin
                in_ready[i] = !rst && grant_valid && load_en;
                grant_data  = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign accept = |(in_valid & in_ready);

    // A drain and a fresh accept on the same edge simply overwrite the register.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            out_count <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= grant_data;
            out_ch    <= grant_idx;
            out_count <= out_count + CNT_W'(1);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_nto1_reg.sv
// Directed self-checking bench for mux_nto1_reg (WIDTH=8, N=4, SEL_W=3, CNT_W=4).
module tb_mux_nto1_reg;

    logic        clk;
    logic        rst;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [2:0]  sel;
    logic [7:0]  out_data;
    logic [2:0]  out_ch;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_count;

    int checks;
    int failures;

    mux_nto1_reg #(
        .WIDTH (8),
        .N     (4),
        .SEL_W (3),
        .CNT_W (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [3:0] valid, input logic [2:0] s,
                                  input logic ordy, input logic [31:0] data);
        in_valid  = valid;
        sel       = s;
        out_ready = ordy;
        in_data   = data;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        apply_stimulus(4'b1111, 3'd2, 1'b1, 32'h44332211);
        checks++;
        if (in_ready !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_in_ready: got %b expected 0000", in_ready);
        end
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_count !== 4'd0 || out_data !== 8'h00 || out_ch !== 3'd0) begin
            failures++;
            $display("[TB] FAIL reset_state: got valid=%b count=%0d data=%h ch=%0d expected 0/0/00/0",
                     out_valid, out_count, out_data, out_ch);
        end
        checks++;
        if (in_ready !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_in_ready_hold: got %b expected 0000", in_ready);
        end
        rst = 1'b0;
        apply_stimulus(4'b0000, 3'd0, 1'b1, 32'h0);
    endtask

    task automatic test_fixed_load();
        apply_stimulus(4'b0100, 3'd2, 1'b1, 32'h33A51100);
        checks++;
        if (in_ready !== 4'b0100) begin
            failures++;
            $display("[TB] FAIL fixed_in_ready: got %b expected 0100", in_ready);
        end
        tick();
        checks++;
        if (out_data !== 8'hA5 || out_ch !== 3'd2 || out_valid !== 1'b1 || out_count !== 4'd1) begin
            failures++;
            $display("[TB] FAIL fixed_load: got data=%h ch=%0d valid=%b count=%0d expected A5/2/1/1",
                     out_data, out_ch, out_valid, out_count);
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(4'b0100, 3'd2, 1'b0, 32'h003C0000);
            checks++;
            if (in_ready !== 4'b0000) begin
                failures++;
                $display("[TB] FAIL stall_in_ready: got %b expected 0000", in_ready);
            end
            tick();
            checks++;
            if (out_data !== 8'hA5 || out_valid !== 1'b1 || out_count !== 4'd1 || out_ch !== 3'd2) begin
                failures++;
                $display("[TB] FAIL stall_hold: got data=%h valid=%b count=%0d ch=%0d expected A5/1/1/2",
                         out_data, out_valid, out_count, out_ch);
            end
        end
        apply_stimulus(4'b0100, 3'd2, 1'b1, 32'h003C0000);
        checks++;
        if (in_ready !== 4'b0100) begin
            failures++;
            $display("[TB] FAIL release_in_ready: got %b expected 0100", in_ready);
        end
        tick();
        checks++;
        if (out_data !== 8'h3C || out_valid !== 1'b1 || out_count !== 4'd2) begin
            failures++;
            $display("[TB] FAIL no_bubble: got data=%h valid=%b count=%0d expected 3C/1/2",
                     out_data, out_valid, out_count);
        end
        apply_stimulus(4'b0000, 3'd2, 1'b1, 32'h00770000);
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h3C || out_ch !== 3'd2 || out_count !== 4'd2) begin
            failures++;
            $display("[TB] FAIL drain: got valid=%b data=%h ch=%0d count=%0d expected 0/3C/2/2",
                     out_valid, out_data, out_ch, out_count);
        end
    endtask

    task automatic test_sel_range();
        apply_stimulus(4'b1111, 3'd5, 1'b1, 32'h44332211);
        checks++;
        if (in_ready !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL sel_oor_in_ready: got %b expected 0000", in_ready);
        end
        tick();
        checks++;
        if (out_count !== 4'd2 || out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL sel_oor_count: got count=%0d valid=%b expected 2/0", out_count, out_valid);
        end
        apply_stimulus(4'b0000, 3'd1, 1'b1, 32'h44332211);
        checks++;
        if (in_ready !== 4'b0010) begin
            failures++;
            $display("[TB] FAIL ready_without_valid: got %b expected 0010", in_ready);
        end
        tick();
        checks++;
        if (out_count !== 4'd2 || out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL no_valid_no_accept: got count=%0d valid=%b expected 2/0", out_count, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_data [4];
        logic [3:0] exp_count;
        exp_data[0] = 8'h10;
        exp_data[1] = 8'h21;
        exp_data[2] = 8'h32;
        exp_data[3] = 8'h43;
        exp_count = 4'd2;
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(4'b1111, 3'(3 - i), 1'b1, 32'h43322110);
            tick();
            exp_count = exp_count + 4'd1;
            checks++;
            if (out_ch !== 3'(3 - i) || out_data !== exp_data[3 - i] || out_valid !== 1'b1 ||
                out_count !== exp_count) begin
                failures++;
                $display("[TB] FAIL back_to_back[%0d]: got ch=%0d data=%h valid=%b count=%0d expected %0d/%h/1/%0d",
                         i, out_ch, out_data, out_valid, out_count, 3 - i, exp_data[3 - i], exp_count);
            end
        end
    endtask

    task automatic test_count_wrap();
        rst = 1'b1;
        apply_stimulus(4'b0000, 3'd0, 1'b1, 32'h000000C7);
        tick();
        rst = 1'b0;
        apply_stimulus(4'b0001, 3'd0, 1'b1, 32'h000000C7);
        for (int i = 0; i < 16; i++) begin
            tick();
        end
        checks++;
        if (out_count !== 4'd0 || out_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL count_16: got count=%0d valid=%b expected 0/1", out_count, out_valid);
        end
        tick();
        checks++;
        if (out_count !== 4'd1 || out_data !== 8'hC7 || out_ch !== 3'd0) begin
            failures++;
            $display("[TB] FAIL count_wrap: got count=%0d data=%h ch=%0d expected 1/C7/0",
                     out_count, out_data, out_ch);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL mid_reset_in_ready: got %b expected 0000", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_count !== 4'd0 || out_data !== 8'h00) begin
            failures++;
            $display("[TB] FAIL mid_reset: got valid=%b count=%0d data=%h expected 0/0/00",
                     out_valid, out_count, out_data);
        end
        rst = 1'b0;
        apply_stimulus(4'b0000, 3'd0, 1'b1, 32'h0);
    endtask

`ifdef MUX_RR_ARB_EN
    task automatic test_round_robin();
        rst = 1'b1;
        apply_stimulus(4'b0000, 3'd0, 1'b1, 32'h0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(4'b1111, 3'd6, 1'b1, 32'h43322110);
            tick();
            checks++;
            if (out_ch !== 3'(i % 4) || out_valid !== 1'b1) begin
                failures++;
                $display("[TB] FAIL rr_all[%0d]: got ch=%0d valid=%b expected %0d/1", i, out_ch, out_valid, i % 4);
            end
        end
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(4'b1010, 3'd0, 1'b1, 32'h43322110);
            tick();
            checks++;
            if (out_ch !== ((i % 2 == 0) ? 3'd1 : 3'd3)) begin
                failures++;
                $display("[TB] FAIL rr_1010[%0d]: got ch=%0d expected %0d", i, out_ch, (i % 2 == 0) ? 1 : 3);
            end
        end
    endtask
`endif

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        sel       = '0;
        out_ready = 1'b0;
        test_reset();
`ifndef MUX_RR_ARB_EN
        test_fixed_load();
        test_backpressure();
        test_sel_range();
        test_back_to_back();
`else
        test_round_robin();
`endif
        test_count_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
